// File: rtl/retrodack_fetch_pkg.sv
// Shared types for the boot-ROM prefetch stage.
package retrodack_fetch_pkg;

  typedef enum logic {IDLE, STREAM} fetch_state_t;

  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] data;
  } prefetch_entry_t;

  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/retrodack_prefetch_fifo.sv
// Prefetch FIFO of {word address, data}; synchronous flush wins over push.
module retrodack_prefetch_fifo
  import retrodack_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  prefetch_entry_t          i_data,
  output prefetch_entry_t          o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  prefetch_entry_t mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic            do_push, do_pop;

  // Push is allowed at full when the head leaves in the same cycle.
  assign do_pop  = i_pop && (o_count != '0);
  assign do_push = i_push && ((o_count != FULL) || do_pop);
  assign o_head  = mem[rd_ptr];

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      o_count <= o_count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge i_clock) begin
    if (do_push && !i_flush && !i_reset) mem[wr_ptr] <= i_data;
  end

endmodule

// File: rtl/retrodack_brom_prefetch.sv
// Sequential prefetcher in front of the boot ROM: FIFO hits in one cycle,
// misses flush and re-seed the stream, responses bypass to a waiting CPU.
module retrodack_brom_prefetch
  import retrodack_fetch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] ROM_BASE  = 32'h0,
  parameter int          ROM_WORDS = 4096
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic [31:0] i_address,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_rom_request,
  output logic [31:0] o_rom_address,
  input  logic [31:0] i_rom_rdata,
  input  logic        i_rom_ready
);

  localparam int          CW     = $clog2(DEPTH) + 1;
  localparam logic [32:0] ROM_END = {1'b0, ROM_BASE} + (33'(ROM_WORDS) << WORD_SHIFT);
  localparam logic [CW:0] CREDIT = (CW+1)'(DEPTH);

  fetch_state_t    state, state_nx;
  logic [31:0]     fetch_addr, fetch_addr_nx;
  logic [29:0]     rsp_waddr, rsp_waddr_nx;
  logic [CW-1:0]   in_flight, in_flight_nx, discard, discard_nx, fifo_count;
  logic            wait_q, wait_nx;
  logic            ready_nx, rom_req_nx;
  logic [31:0]     rdata_nx, rom_addr_nx;

  prefetch_entry_t head, push_data;
  logic [29:0]     req_waddr;
  logic [31:0]     req_addr;
  logic            req_in_rom, accept, rsp_vld, rsp_live;
  logic            head_hit, pend_hit, hit, pend, miss, bypass, push;
  logic [CW-1:0]   live_flight;
  logic [CW:0]     credit;
  logic            addr_lsb_unused;

  assign addr_lsb_unused = ^i_address[WORD_SHIFT-1:0];

  assign req_waddr   = i_address[31:WORD_SHIFT];
  assign req_addr    = {req_waddr, 2'b00};
  assign req_in_rom  = ({1'b0, req_addr} >= {1'b0, ROM_BASE}) && ({1'b0, req_addr} < ROM_END);
  assign accept      = i_request && !o_ready && !wait_q;
  // A response with nothing outstanding belongs to a stream killed by reset.
  assign rsp_vld     = i_rom_ready && (in_flight != '0);
  assign rsp_live    = rsp_vld && (discard == '0);
  assign live_flight = in_flight - discard;
  assign credit      = {1'b0, fifo_count} + {1'b0, in_flight};

  assign head_hit = (state == STREAM) && (fifo_count != '0) && (head.word_addr == req_waddr);
  // FIFO empty but the wanted word is the next live response: wait for it.
  assign pend_hit = (state == STREAM) && (fifo_count == '0) && req_in_rom &&
                    (live_flight != '0) && (rsp_waddr == req_waddr);

  assign hit       = accept && head_hit;
  assign pend      = accept && pend_hit;
  assign miss      = accept && !head_hit && !pend_hit;
  assign bypass    = rsp_live && (wait_q || pend);
  assign push      = rsp_live && !bypass;
  assign push_data = '{word_addr: rsp_waddr, data: i_rom_rdata};

  retrodack_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (push),
    .i_pop   (hit),
    .i_flush (miss),
    .i_data  (push_data),
    .o_head  (head),
    .o_count (fifo_count)
  );

  always_comb begin
    state_nx      = state;
    fetch_addr_nx = fetch_addr;
    rsp_waddr_nx  = rsp_waddr;
    wait_nx       = wait_q;
    rom_req_nx    = 1'b0;
    rom_addr_nx   = o_rom_address;
    ready_nx      = 1'b0;
    rdata_nx      = o_rdata;
    discard_nx    = discard - CW'(rsp_vld && (discard != '0));

    if (miss) begin
      // Everything outstanding, including a response landing now, is stale.
      state_nx      = req_in_rom ? STREAM : IDLE;
      discard_nx    = in_flight - CW'(rsp_vld);
      rsp_waddr_nx  = req_waddr;
      wait_nx       = req_in_rom;
      fetch_addr_nx = req_addr + 32'd4;
      rom_req_nx    = req_in_rom;
      rom_addr_nx   = req_addr;
      if (!req_in_rom) begin
        ready_nx = 1'b1;
        rdata_nx = 32'h0;
      end
    end else begin
      if (rsp_live) rsp_waddr_nx = rsp_waddr + 30'd1;
      if (pend && !rsp_live) wait_nx = 1'b1;
      if (bypass) wait_nx = 1'b0;
      if ((state == STREAM) && (credit < CREDIT) && ({1'b0, fetch_addr} < ROM_END)) begin
        rom_req_nx    = 1'b1;
        rom_addr_nx   = fetch_addr;
        fetch_addr_nx = fetch_addr + 32'd4;
      end
    end

    if (hit) begin
      ready_nx = 1'b1;
      rdata_nx = head.data;
    end else if (bypass) begin
      ready_nx = 1'b1;
      rdata_nx = i_rom_rdata;
    end

    in_flight_nx = in_flight - CW'(rsp_vld) + CW'(rom_req_nx);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      fetch_addr    <= '0;
      rsp_waddr     <= '0;
      in_flight     <= '0;
      discard       <= '0;
      wait_q        <= 1'b0;
      o_ready       <= 1'b0;
      o_rdata       <= '0;
      o_rom_request <= 1'b0;
      o_rom_address <= '0;
    end else begin
      state         <= state_nx;
      fetch_addr    <= fetch_addr_nx;
      rsp_waddr     <= rsp_waddr_nx;
      in_flight     <= in_flight_nx;
      discard       <= discard_nx;
      wait_q        <= wait_nx;
      o_ready       <= ready_nx;
      o_rdata       <= rdata_nx;
      o_rom_request <= rom_req_nx;
      o_rom_address <= rom_addr_nx;
    end
  end

endmodule

// File: tb/tb_retrodack_brom_prefetch.sv
// Directed bench for the boot-ROM prefetcher with a 1-cycle ROM model.
module tb_retrodack_brom_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        rdy;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic [31:0] rom_rdata = '0;
  logic        rom_rdy = 1'b0;

  int checks = 0;
  int failures = 0;
  int bad_align = 0;
  int bad_range = 0;
  int max_credit = 0;

  always #5 clk = ~clk;

  retrodack_brom_prefetch #(.DEPTH(4), .ROM_BASE(32'h0), .ROM_WORDS(4096)) u_dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_request     (req),
    .i_address     (addr),
    .o_rdata       (rdata),
    .o_ready       (rdy),
    .o_rom_request (rom_req),
    .o_rom_address (rom_addr),
    .i_rom_rdata   (rom_rdata),
    .i_rom_ready   (rom_rdy)
  );

  // ROM word n holds {16'hC0DE, n}.
  always @(posedge clk) begin
    rom_rdy   <= rom_req;
    rom_rdata <= {16'hC0DE, rom_addr[17:2]};
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rom_req && rom_addr[1:0] != 2'b00) bad_align++;
      if (rom_req && rom_addr >= 32'h4000) bad_range++;
      if (int'(u_dut.fifo_count) + int'(u_dut.in_flight) > max_credit)
        max_credit = int'(u_dut.fifo_count) + int'(u_dut.in_flight);
    end
  end

  task automatic do_fetch(input logic [31:0] a, output logic [31:0] d, output int lat);
    @(posedge clk); #1;
    req = 1'b1; addr = a; lat = 99; d = 32'hDEAD_DEAD;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (rdy) begin lat = c; d = rdata; break; end
    end
    req = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL %s o_ready got %b want 0", tag, rdy); end
    checks++; if (rom_req !== 1'b0) begin failures++; $display("FAIL %s o_rom_request got %b want 0", tag, rom_req); end
    checks++; if (rom_addr !== 32'h0) begin failures++; $display("FAIL %s o_rom_address got %h want 0", tag, rom_addr); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL %s o_rdata got %h want 0", tag, rdata); end
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] d, input int lat,
                             input logic [31:0] exp_d, input int exp_lat);
    checks++; if (lat != exp_lat) begin failures++; $display("FAIL %s latency got %0d want %0d", tag, lat, exp_lat); end
    checks++; if (d !== exp_d) begin failures++; $display("FAIL %s data got %h want %h", tag, d, exp_d); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
  endtask

  task automatic test_first_miss();
    @(posedge clk); #1;
    req = 1'b1; addr = 32'h0;
    @(posedge clk); #1;
    checks++; if (rom_req !== 1'b1) begin failures++; $display("FAIL first_strobe got %b want 1", rom_req); end
    checks++; if (rom_addr !== 32'h0) begin failures++; $display("FAIL first_rom_addr got %h want 0", rom_addr); end
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL first_early_c1 got %b want 0", rdy); end
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL first_early_c2 got %b want 0", rdy); end
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL first_ready_c3 got %b want 1", rdy); end
    checks++; if (rdata !== 32'hC0DE0000) begin failures++; $display("FAIL first_data got %h want c0de0000", rdata); end
    req = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] d;
    int lat;
    for (int i = 1; i < 16; i++) begin
      do_fetch(32'(i * 4), d, lat);
      check_fetch($sformatf("seq_%0d", i), d, lat, {16'hC0DE, 16'(i)}, 1);
    end
    checks++; if (max_credit > 4) begin failures++; $display("FAIL seq_credit got %0d want <=4", max_credit); end
  endtask

  task automatic test_jump();
    logic [31:0] d;
    int lat;
    do_fetch(32'h10, d, lat);
    check_fetch("jump_seed", d, lat, 32'hC0DE0004, 3);
    do_fetch(32'h200, d, lat);
    check_fetch("jump_target", d, lat, 32'hC0DE0080, 3);
    do_fetch(32'h204, d, lat);
    check_fetch("jump_next_hit", d, lat, 32'hC0DE0081, 1);
  endtask

  task automatic test_end_of_rom();
    logic [31:0] d;
    int lat;
    do_fetch(32'h3FFC, d, lat);
    check_fetch("rom_last", d, lat, 32'hC0DE0FFF, 3);
    repeat (6) @(posedge clk);
    #1;
    checks++; if (bad_range != 0) begin failures++; $display("FAIL rom_past_end got %0d strobes want 0", bad_range); end
    checks++; if (u_dut.fifo_count !== '0) begin failures++; $display("FAIL rom_end_fifo got %0d want 0", u_dut.fifo_count); end
    do_fetch(32'h4000, d, lat);
    check_fetch("out_of_range", d, lat, 32'h0, 1);
  endtask

  task automatic test_reset_mid_stream();
    logic [31:0] d;
    int lat;
    do_fetch(32'h0, d, lat);
    check_fetch("pre_reset", d, lat, 32'hC0DE0000, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("mid_reset");
    rst = 1'b0;
    do_fetch(32'h8, d, lat);
    check_fetch("post_reset_miss", d, lat, 32'hC0DE0002, 3);
  endtask

  task automatic test_unaligned();
    logic [31:0] d;
    int lat;
    do_fetch(32'h2, d, lat);
    check_fetch("unaligned", d, lat, 32'hC0DE0000, 3);
    checks++; if (bad_align != 0) begin failures++; $display("FAIL rom_align got %0d bad strobes want 0", bad_align); end
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_sequential();
    test_jump();
    test_end_of_rom();
    test_reset_mid_stream();
    test_unaligned();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
